tff_pattern_sequencer: RTL and testbench
========================================

// Module: tff_pattern_sequencer
// PURPOSE
// - Sequences the T input of a T flip-flop from a stored serial toggle pattern, LSB first, one bit per clk.
// - Captures the flip-flop's Q after every applied bit into a history register, then reports completion.
// - Sits between a host or test controller and a T flip-flop cell; replaces hand-written per-cycle T stimulus.
// PARAMETERS
// - PAT_W  16  pattern and capture length in bits (2..32)
// - LEN_W  5   width of len; must hold PAT_W, i.e. $clog2(PAT_W)+1
// PORTS
// - clk      in   1      rising-edge clock
// - rst      in   1      asynchronous reset, active-high
// - load     in   1      latch pat_in into pattern register (accepted only in IDLE)
// - pat_in   in   PAT_W  toggle pattern; bit i is driven as T in step i
// - len      in   LEN_W  number of steps to run, sampled with start
// - start    in   1      begin a run (accepted only in IDLE)
// - abort    in   1      cancel an active run
// - q_in     in   1      Q of the controlled flip-flop (ignored when TFF_SEQ_MODEL_EN is defined)
// - t_out    out  1      T drive to the flip-flop
// - busy     out  1      high in RUN and FLUSH
// - done     out  1      one-cycle completion pulse
// - capture  out  PAT_W  capture[i] = Q after step i was applied
// - q_mon    out  1      internal model Q; present only when TFF_SEQ_MODEL_EN is defined
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE, pattern=0, capture=0, idx=0, t_out=0, busy=0, done=0, q_mon=0.
// - States: IDLE -> RUN -> FLUSH -> DONE -> IDLE. The state register changes on clk rising edges only.
// - t_out is combinational: pattern[idx] when state is RUN, otherwise 0.
// - IDLE: load=1 latches pat_in. start=1 with len!=0 enters RUN with idx=0. Effective length is min(len,PAT_W).
//   - On entering RUN, capture is cleared.
//   - start with len=0 is ignored.
//   - load and start in the same cycle: the run uses the newly loaded pat_in.
// - RUN: idx increments each edge.
//   - At edge k+1 (k>=1, counted from the start edge E0), capture[k-1] <= q_in.
//   - When idx = len-1, the next edge goes to FLUSH.
// - FLUSH: one edge; capture[len-1] <= q_in; go to DONE.
// - DONE: done=1 for exactly one cycle, then IDLE.
// - Timing: start sampled at E0; busy=1 from E0 through E(len+1); done is high in the cycle after E(len+1).
// - load, start and len are ignored outside IDLE.
// - capture holds its value until the next accepted start. Bits at index >= len stay 0.
// - abort=1 in RUN or FLUSH: the next edge goes to IDLE; done is not pulsed; captured bits are kept.
//   - t_out still drives pattern[idx] during the abort cycle, so one final toggle can occur.
//   - abort in IDLE or DONE is ignored.
// - rst mid-run: immediate return to reset values; no done pulse.
// CONFIGURATION
// - TFF_SEQ_MODEL_EN defined: instantiates an internal T flip-flop model.
//   - The model toggles q on each edge where t_out=1; reset value 0.
//   - Captures are taken from the model instead of q_in; model Q is exposed on q_mon.
// - TFF_SEQ_MODEL_EN undefined: no model and no q_mon port; captures come from q_in.
// STRUCTURE
// - Shared package tff_seq_pkg: state enum (IDLE, RUN, FLUSH, DONE) and localparam defaults for PAT_W/LEN_W.
// - One sub-module, t_toggle_cell (inputs clk, rst, t; outputs q, qb; async active-high reset).
//   - Used for the model under TFF_SEQ_MODEL_EN.
// - All other logic (FSM, idx counter, pattern/capture registers) is in this module.
// TESTING
// - Model enabled: pat_in=16'b0101001110011111, len=16, load+start together.
//   - Expect capture=16'h3175, done 17 cycles after the start edge, busy high for those 17 cycles.
// - Same pattern, len=4: capture=16'h0005; q_mon=0 at done; done after 5 cycles.
// - len=0 with start: busy stays 0, done never pulses, capture unchanged.
// - len=20 (>PAT_W): clamped to 16; result identical to scenario 1.
// - abort asserted in the 3rd RUN cycle:
//   - IDLE on the next edge, no done.
//   - capture[0]=1, capture[1]=0, capture[15:2]=0.
//   - load or start during RUN is ignored.
// - rst pulse mid-RUN: all outputs return to 0 asynchronously; a fresh start then runs normally.

Source files
------------

// File: rtl/tff_seq_pkg.sv
// Shared types and defaults for the T flip-flop pattern sequencer.
package tff_seq_pkg;

    localparam int unsigned PAT_W_DEF = 16;
    localparam int unsigned LEN_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/t_toggle_cell.sv
// T flip-flop cell: q inverts on each rising clk edge where t is high.
module t_toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/tff_pattern_sequencer.sv
// Drives a stored toggle pattern onto a T flip-flop LSB first and records Q after each step.
// Define TFF_SEQ_MODEL_EN to use an internal flip-flop model (exposed on q_mon) instead of q_in.
module tff_pattern_sequencer
    import tff_seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len,
    input  logic             start,
    input  logic             abort,
    input  logic             q_in,
    output logic             t_out,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] capture
`ifdef TFF_SEQ_MODEL_EN
    ,
    output logic             q_mon
`endif
);

    seq_state_e       state;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W-1:0] cap_ptr;
    logic [PAT_W-1:0] cap_sel;
    logic             cap_en;
    logic             q_src;

`ifdef TFF_SEQ_MODEL_EN
    logic unused_qb;
    logic unused_q_in;

    t_toggle_cell u_model (
        .clk (clk),
        .rst (rst),
        .t   (t_out),
        .q   (q_mon),
        .qb  (unused_qb)
    );

    assign q_src       = q_mon;
    assign unused_q_in = q_in;
`else
    assign q_src = q_in;
`endif

    // Requests longer than the pattern register run the full pattern.
    assign len_clamp = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;

    // Step k's result is stable one cycle after it is applied, so the write slot lags idx by one.
    assign cap_ptr = idx - LEN_W'(1);
    assign cap_en  = ((state == RUN && idx != '0) || state == FLUSH) && !abort;

    // Decode the bit driven as T and the capture slot being written.
    always_comb begin
        cap_sel = '0;
        t_out   = 1'b0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            if (cap_ptr == LEN_W'(i)) begin
                cap_sel[i] = 1'b1;
            end
            if (state == RUN && idx == LEN_W'(i)) begin
                t_out = pattern[i];
            end
        end
    end

    // Sequencer state, step counter and pattern/capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pattern <= '0;
            capture <= '0;
            idx     <= '0;
            len_eff <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cap_en) begin
                capture <= (capture & ~cap_sel) | (cap_sel & {PAT_W{q_src}});
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        pattern <= pat_in;
                    end
                    if (start && len != '0) begin
                        state   <= RUN;
                        idx     <= '0;
                        len_eff <= len_clamp;
                        capture <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + LEN_W'(1);
                        if (idx == len_eff - LEN_W'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= abort ? IDLE : DONE;
                    done  <= !abort;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_pattern_sequencer.sv
// Directed scenario bench for tff_pattern_sequencer; builds with or without TFF_SEQ_MODEL_EN.
module tb_tff_pattern_sequencer;

    localparam logic [15:0] PAT = 16'b0101001110011111;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] pat_in;
    logic [4:0]  len;
    logic        start;
    logic        abort;
    logic        q_in;
    logic        t_out;
    logic        busy;
    logic        done;
    logic [15:0] capture;
`ifdef TFF_SEQ_MODEL_EN
    logic        q_mon;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    tff_pattern_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .pat_in  (pat_in),
        .len     (len),
        .start   (start),
        .abort   (abort),
        .q_in    (q_in),
        .t_out   (t_out),
        .busy    (busy),
        .done    (done),
        .capture (capture)
`ifdef TFF_SEQ_MODEL_EN
        ,
        .q_mon   (q_mon)
`endif
    );

    always #5 clk = ~clk;

    // External T flip-flop the sequencer controls through t_out / q_in.
    always @(posedge clk or posedge rst) begin
        if (rst) q_in <= 1'b0;
        else if (t_out) q_in <= ~q_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start (optionally with load) and waits for done, counting busy cycles.
    task automatic run_seq(input logic [15:0] pat, input logic [4:0] l, input logic do_load,
                           output int done_k, output int busy_cnt);
        pat_in = pat;
        len    = l;
        load   = do_load;
        start  = 1'b1;
        tick();
        load     = 1'b0;
        start    = 1'b0;
        done_k   = 0;
        busy_cnt = 0;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                done_k = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; pat_in = '0; len = '0; start = 1'b0; abort = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (capture !== 16'h0000) $display("FAIL reset_capture got %h want 0000", capture); else n_pass++;
        n_checks++; if (t_out !== 1'b0) $display("FAIL reset_t_out got %b want 0", t_out); else n_pass++;
`ifdef TFF_SEQ_MODEL_EN
        n_checks++; if (q_mon !== 1'b0) $display("FAIL reset_q_mon got %b want 0", q_mon); else n_pass++;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done); else n_pass++;
    endtask

    task automatic test_full_run();
        int dk, bc;
        run_seq(PAT, 5'd16, 1'b1, dk, bc);
        n_checks++; if (dk !== 17) $display("FAIL full_done_latency got %0d want 17", dk); else n_pass++;
        n_checks++; if (bc !== 17) $display("FAIL full_busy_cycles got %0d want 17", bc); else n_pass++;
        n_checks++; if (capture !== 16'h3175) $display("FAIL full_capture got %h want 3175", capture); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL full_done_width got %b want 0", done); else n_pass++;
    endtask

    task automatic test_short_run();
        int dk, bc;
        run_seq(PAT, 5'd4, 1'b1, dk, bc);
        n_checks++; if (dk !== 5) $display("FAIL short_done_latency got %0d want 5", dk); else n_pass++;
        n_checks++; if (bc !== 5) $display("FAIL short_busy_cycles got %0d want 5", bc); else n_pass++;
        n_checks++; if (capture !== 16'h0005) $display("FAIL short_capture got %h want 0005", capture); else n_pass++;
`ifdef TFF_SEQ_MODEL_EN
        n_checks++; if (q_mon !== 1'b0) $display("FAIL short_q_mon got %b want 0", q_mon); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_len_zero();
        int busy_seen, done_seen;
        busy_seen = 0;
        done_seen = 0;
        len   = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (busy) busy_seen++;
            if (done) done_seen++;
            tick();
        end
        n_checks++; if (busy_seen !== 0) $display("FAIL len0_busy got %0d busy cycles want 0", busy_seen); else n_pass++;
        n_checks++; if (done_seen !== 0) $display("FAIL len0_done got %0d done cycles want 0", done_seen); else n_pass++;
        n_checks++; if (capture !== 16'h0005) $display("FAIL len0_capture got %h want 0005", capture); else n_pass++;
    endtask

    task automatic test_len_clamp();
        int dk, bc;
        run_seq(16'h0000, 5'd20, 1'b0, dk, bc);
        n_checks++; if (dk !== 17) $display("FAIL clamp_done_latency got %0d want 17", dk); else n_pass++;
        n_checks++; if (bc !== 17) $display("FAIL clamp_busy_cycles got %0d want 17", bc); else n_pass++;
        n_checks++; if (capture !== 16'h3175) $display("FAIL clamp_capture got %h want 3175", capture); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        pat_in = PAT; len = 5'd16; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        n_checks++; if (t_out !== 1'b1) $display("FAIL abort_t_step0 got %b want 1", t_out); else n_pass++;
        tick();
        // Load and start while running must be ignored.
        pat_in = 16'h0000; len = 5'd3; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        n_checks++; if (t_out !== 1'b1) $display("FAIL abort_t_step2 got %b want 1", t_out); else n_pass++;
        n_checks++; if (capture !== 16'h0001) $display("FAIL abort_mid_capture got %h want 0001", capture); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_mid_busy got %b want 1", busy); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (t_out !== 1'b0) $display("FAIL abort_t_out got %b want 0", t_out); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (done) done_seen++;
            tick();
        end
        n_checks++; if (done_seen !== 0) $display("FAIL abort_done got %0d pulses want 0", done_seen); else n_pass++;
        n_checks++; if (capture !== 16'h0001) $display("FAIL abort_capture got %h want 0001", capture); else n_pass++;
`ifdef TFF_SEQ_MODEL_EN
        n_checks++; if (q_mon !== 1'b1) $display("FAIL abort_q_mon got %b want 1", q_mon); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_run();
        int dk, bc;
        pat_in = PAT; len = 5'd16; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_checks++; if (capture !== 16'h0000) $display("FAIL rst_capture got %h want 0000", capture); else n_pass++;
        n_checks++; if (t_out !== 1'b0) $display("FAIL rst_t_out got %b want 0", t_out); else n_pass++;
`ifdef TFF_SEQ_MODEL_EN
        n_checks++; if (q_mon !== 1'b0) $display("FAIL rst_q_mon got %b want 0", q_mon); else n_pass++;
`endif
        #2;
        rst = 1'b0;
        tick();
        run_seq(PAT, 5'd16, 1'b1, dk, bc);
        n_checks++; if (dk !== 17) $display("FAIL rerun_done_latency got %0d want 17", dk); else n_pass++;
        n_checks++; if (capture !== 16'h3175) $display("FAIL rerun_capture got %h want 3175", capture); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_short_run();
        test_len_zero();
        test_len_clamp();
        test_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
